// File: rtl/memory_bus_sizes_pkg.sv
// Shared bus widths, access-size encoding and data-memory FSM states.
// No logic; consumed by the hub interface and the data-memory master.
package memory_bus_sizes;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        DONE    = 3'd5
    } dmem_state_t;

    localparam logic [DATA_WIDTH-1:0] DEADBEEF_WORD = 32'hDEADBEEF;

    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] off);
        return ((size == SIZE_HALF) && off[0]) || ((size == SIZE_WORD) && (off != 2'b00));
    endfunction
endpackage

// File: rtl/axi_bus_rw.sv
// Request/response channel bundle between a memory client and the memory hub.
// Completion of both reads and writes is reported on read_data_valid.
interface axi_bus_rw;
    logic [memory_bus_sizes::ADDR_WIDTH-1:0] read_addr;
    logic                                    read_addr_valid;
    logic                                    read_addr_ready;
    logic [memory_bus_sizes::DATA_WIDTH-1:0] read_data;
    logic                                    read_data_valid;
    logic [memory_bus_sizes::ADDR_WIDTH-1:0] write_addr;
    logic [memory_bus_sizes::DATA_WIDTH-1:0] write_data;
    logic                                    write_addr_valid;
    logic                                    write_addr_ready;

    modport controller (
        output read_addr, read_addr_valid, write_addr, write_data, write_addr_valid,
        input  read_addr_ready, read_data, read_data_valid, write_addr_ready
    );
    modport device (
        input  read_addr, read_addr_valid, write_addr, write_data, write_addr_valid,
        output read_addr_ready, read_data, read_data_valid, write_addr_ready
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte/half lane extraction with sign extension for loads, lane merge for stores.
// Purely combinational; no latency, no flow control.
module dmem_lane_align
    import memory_bus_sizes::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  mem_size_t   size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane  = word[{offset, 3'b000} +: 8];
        half_lane  = word[{offset[1], 4'b0000} +: 16];
        load_data  = word;
        store_word = word;
        case (size)
            SIZE_BYTE: begin
                load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
                store_word[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_HALF: begin
                // Half lanes ignore offset[0], which truncates a misaligned half.
                load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
                store_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end
endmodule

// File: rtl/dmem_bus_master.sv
// CPU load/store to hub transactions with sub-word read-modify-write; BUS_TIMEOUT_EN adds a WAIT watchdog.
// Latency: word access DONE at T0+D+3, sub-word store T0+2D+5; stalls CPU until done, holds valid until ready.
module dmem_bus_master
    import memory_bus_sizes::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_en,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_unsigned,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_err,
    axi_bus_rw.controller mhub
);
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("dmem_bus_master: TIMEOUT_CYCLES must be at least 1");
    end

    dmem_state_t state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] wr_data_q;
    mem_size_t   size_q;
    logic        we_q;
    logic        uns_q;
    logic        rd_vld_q;
    logic        wr_vld_q;
    mem_size_t   size_n;
    logic [31:0] load_data;
    logic [31:0] store_word;
    logic        idle_err;

    assign size_n   = (cpu_size == 2'd3) ? SIZE_WORD : mem_size_t'(cpu_size);
    assign idle_err = (state == IDLE) && cpu_en && is_misaligned(size_n, cpu_addr[1:0]);
    assign cpu_stall = ((state != IDLE) && (state != DONE)) || ((state == IDLE) && cpu_en);

    assign mhub.read_addr        = {addr_q[31:2], 2'b00};
    assign mhub.read_addr_valid  = rd_vld_q;
    assign mhub.write_addr       = {addr_q[31:2], 2'b00};
    assign mhub.write_data       = wr_data_q;
    assign mhub.write_addr_valid = wr_vld_q;

    // The merge sees the word on read_data during RD_WAIT, so no separate read buffer is kept.
    dmem_lane_align u_align (
        .word        (mhub.read_data),
        .offset      (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .store_word  (store_word)
    );

`ifdef BUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt;
    logic            err_to_q;
    assign cpu_err = idle_err | err_to_q;
`else
    assign cpu_err = idle_err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_data_q <= '0;
            size_q    <= SIZE_WORD;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            rd_vld_q  <= 1'b0;
            wr_vld_q  <= 1'b0;
            cpu_rdata <= '0;
`ifdef BUS_TIMEOUT_EN
            to_cnt    <= '0;
            err_to_q  <= 1'b0;
`endif
        end else begin
`ifdef BUS_TIMEOUT_EN
            err_to_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (cpu_en) begin
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        size_q  <= size_n;
                        we_q    <= cpu_we;
                        uns_q   <= cpu_unsigned;
                        if (cpu_we && (size_n == SIZE_WORD)) begin
                            wr_data_q <= cpu_wdata;
                            wr_vld_q  <= 1'b1;
                            state     <= WR_REQ;
                        end else begin
                            rd_vld_q <= 1'b1;
                            state    <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (mhub.read_addr_ready) begin
                        rd_vld_q <= 1'b0;
                        state    <= RD_WAIT;
`ifdef BUS_TIMEOUT_EN
                        to_cnt   <= '0;
`endif
                    end
                end
                RD_WAIT: begin
                    if (mhub.read_data_valid) begin
                        if (we_q) begin
                            wr_data_q <= store_word;
                            wr_vld_q  <= 1'b1;
                            state     <= WR_REQ;
                        end else begin
                            cpu_rdata <= load_data;
                            state     <= DONE;
                        end
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        cpu_rdata <= DEADBEEF_WORD;
                        err_to_q  <= 1'b1;
                        state     <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                WR_REQ: begin
                    if (mhub.write_addr_ready) begin
                        wr_vld_q <= 1'b0;
                        state    <= WR_WAIT;
`ifdef BUS_TIMEOUT_EN
                        to_cnt   <= '0;
`endif
                    end
                end
                WR_WAIT: begin
                    if (mhub.read_data_valid) begin
                        state <= DONE;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        cpu_rdata <= DEADBEEF_WORD;
                        err_to_q  <= 1'b1;
                        state     <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_bus_master.sv
// Directed bench for dmem_bus_master against a behavioural slow RAM (MEM_DELAY=10).
module tb_dmem_bus_master;
    localparam int MEM_DELAY = 10;
`ifdef BUS_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 64;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_en = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [1:0]  cpu_size = '0;
    logic        cpu_unsigned = 1'b0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_err;

    axi_bus_rw bus ();

    dmem_bus_master #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_en       (cpu_en),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_size     (cpu_size),
        .cpu_unsigned (cpu_unsigned),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .cpu_err      (cpu_err),
        .mhub         (bus)
    );

    always #5 clk = ~clk;

    // Slow RAM: one transaction at a time, completion pulse D+1 cycles after acceptance.
    logic [31:0] mem [0:255];
    int          cnt = 0;
    logic        rv = 1'b0;
    logic [31:0] rd = '0;
    logic [7:0]  pend_idx = '0;
    logic        pend_rd = 1'b0;
    int          rd_acc = 0;
    int          wr_acc = 0;
    int          both_vld = 0;

    assign bus.read_addr_ready  = (cnt == 0) && !rv;
    assign bus.write_addr_ready = (cnt == 0) && !rv;
    assign bus.read_data_valid  = rv;
    assign bus.read_data        = rd;

    always @(posedge clk) begin
        if (rv) rv <= 1'b0;
        if (cnt == 1) begin
            cnt <= 0;
            rv  <= 1'b1;
            rd  <= pend_rd ? mem[pend_idx] : 32'h0;
        end else if (cnt > 1) begin
            cnt <= cnt - 1;
        end else if (!rv && bus.read_addr_valid) begin
            cnt      <= MEM_DELAY;
            pend_idx <= bus.read_addr[9:2];
            pend_rd  <= 1'b1;
            rd_acc   <= rd_acc + 1;
        end else if (!rv && bus.write_addr_valid) begin
            cnt                      <= MEM_DELAY;
            mem[bus.write_addr[9:2]] <= bus.write_data;
            pend_rd                  <= 1'b0;
            wr_acc                   <= wr_acc + 1;
        end
    end

    always @(negedge clk) begin
        if (bus.read_addr_valid && bus.write_addr_valid) both_vld <= both_vld + 1;
    end

    int n_assert = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int   done_cyc;
    int   rav_cyc;
    int   rd_before;
    int   wr_before;
    logic err0;
    logic err1;
    logic err_done;

    task automatic access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wd);
        @(posedge clk);
        #1;
        cpu_en = 1'b1; cpu_we = we; cpu_addr = addr; cpu_size = size;
        cpu_unsigned = uns; cpu_wdata = wd;
        rd_before = rd_acc; wr_before = wr_acc;
        done_cyc = -1; rav_cyc = -1; err0 = 1'b0; err1 = 1'b0; err_done = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c == 0) err0 = cpu_err;
            if (c == 1) err1 = cpu_err;
            if (bus.read_addr_valid && rav_cyc < 0) rav_cyc = c;
            if (!cpu_stall) begin
                done_cyc = c;
                err_done = cpu_err;
                break;
            end
        end
        if (done_cyc < 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL done_bound: observed no DONE expected DONE within 300 cycles");
        end
        @(posedge clk);
        #1;
        cpu_en = 1'b0; cpu_we = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[64] = 32'h8899AABB;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
        chk("rst_err", {31'b0, cpu_err}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_rav", {31'b0, bus.read_addr_valid}, 32'd0);
        chk("rst_wav", {31'b0, bus.write_addr_valid}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

`ifdef BUS_TIMEOUT_EN
        access(1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
        chk("to_done", done_cyc, 32'd6);
        chk("to_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("to_err", {31'b0, err_done}, 32'd1);
        chk("to_err_t0", {31'b0, err0}, 32'd0);
`else
        access(1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
        chk("lw_done", done_cyc, 32'd13);
        chk("lw_rav_t1", rav_cyc, 32'd1);
        chk("lw_rdata", cpu_rdata, 32'h8899AABB);
        chk("lw_err_t0", {31'b0, err0}, 32'd0);
        chk("lw_err_done", {31'b0, err_done}, 32'd0);

        access(1'b0, 32'h101, 2'd0, 1'b0, 32'h0);
        chk("lb_rdata", cpu_rdata, 32'hFFFFFFAA);
        access(1'b0, 32'h101, 2'd0, 1'b1, 32'h0);
        chk("lbu_rdata", cpu_rdata, 32'h000000AA);
        access(1'b0, 32'h102, 2'd1, 1'b0, 32'h0);
        chk("lh_rdata", cpu_rdata, 32'hFFFF8899);

        access(1'b1, 32'h102, 2'd0, 1'b0, 32'h00000055);
        chk("sb_done", done_cyc, 32'd25);
        chk("sb_reads", rd_acc - rd_before, 32'd1);
        chk("sb_writes", wr_acc - wr_before, 32'd1);
        access(1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
        chk("sb_readback", cpu_rdata, 32'h8855AABB);

        access(1'b1, 32'h100, 2'd1, 1'b0, 32'hFFFFBEEF);
        chk("sh_done", done_cyc, 32'd25);
        access(1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
        chk("sh_readback", cpu_rdata, 32'h8855BEEF);

        access(1'b1, 32'h104, 2'd2, 1'b0, 32'h12345678);
        chk("sw_done", done_cyc, 32'd13);
        chk("sw_reads", rd_acc - rd_before, 32'd0);
        chk("sw_writes", wr_acc - wr_before, 32'd1);
        chk("sw_no_rav", rav_cyc, 32'hFFFFFFFF);
        access(1'b0, 32'h104, 2'd3, 1'b0, 32'h0);
        chk("sw_readback", cpu_rdata, 32'h12345678);

        access(1'b0, 32'h102, 2'd2, 1'b0, 32'h0);
        chk("mis_lw_err_t0", {31'b0, err0}, 32'd1);
        chk("mis_lw_err_t1", {31'b0, err1}, 32'd0);
        chk("mis_lw_rdata", cpu_rdata, 32'h8855BEEF);
        access(1'b0, 32'h103, 2'd1, 1'b1, 32'h0);
        chk("mis_lhu_err_t0", {31'b0, err0}, 32'd1);
        chk("mis_lhu_rdata", cpu_rdata, 32'h00008855);

        // Reset in cycle T5 of a read while the RAM is still busy with it.
        @(posedge clk);
        #1;
        cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; cpu_size = 2'd2; cpu_unsigned = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        cpu_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_rav", {31'b0, bus.read_addr_valid}, 32'd0);
        chk("arst_wav", {31'b0, bus.write_addr_valid}, 32'd0);
        chk("arst_rdata", cpu_rdata, 32'h0);
        chk("arst_stall", {31'b0, cpu_stall}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        access(1'b0, 32'h104, 2'd2, 1'b0, 32'h0);
        chk("post_rst_rdata", cpu_rdata, 32'h12345678);

        chk("no_dual_valid", both_vld, 32'd0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
